// File: rtl/baser_257b_generator_if.sv
// Configuration and transcoded-word bus of the 257b BASE-R traffic generator.
// The generator takes the master side; the consumer or bench takes the slave side.
interface baser_257b_generator_if #(
  parameter int TC_WIDTH = 257
);
  logic                i_enable;
  logic [7:0]          i_data_blocks;
  logic [2:0]          i_term_bytes;
  logic [7:0]          i_ipg_blocks;
  logic                i_err_inject;
  logic [TC_WIDTH-1:0] o_tx_coded;
  logic                o_valid;
  logic [31:0]         o_block_count;
  logic [31:0]         o_data_count;
  logic [31:0]         o_pkt_count;

  modport master (
    input  i_enable, i_data_blocks, i_term_bytes, i_ipg_blocks, i_err_inject,
    output o_tx_coded, o_valid, o_block_count, o_data_count, o_pkt_count
  );

  modport slave (
    output i_enable, i_data_blocks, i_term_bytes, i_ipg_blocks, i_err_inject,
    input  o_tx_coded, o_valid, o_block_count, o_data_count, o_pkt_count
  );
endinterface

// File: rtl/baser_257b_generator.sv
// 257b transcoded BASE-R traffic generator: sequences S/D/T/I blocks into packets
// and packs four 64b blocks per clock into one registered transcoded word.
module baser_257b_generator #(
  parameter int         DATA_WIDTH        = 64,
  parameter int         TC_WIDTH          = 257,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [6:0] CTRL_CHAR_PATTERN = 7'h1E,
  parameter logic [6:0] IDLE_CHAR_PATTERN = 7'h00
) (
  input logic                    clk,
  input logic                    i_rst_n,
  baser_257b_generator_if.master bus
);
  localparam int SLOTS  = 4;
  localparam int PAY_W  = DATA_WIDTH - 8;
  localparam int BODY_W = TC_WIDTH - 1;

  typedef enum logic {PH_IDLE, PH_DATA} phase_t;
  typedef enum logic [1:0] {BLK_I, BLK_S, BLK_D, BLK_T} blk_t;

  phase_t              phase_q, phase_d;
  logic [7:0]          rem_q, rem_d;
  logic [2:0]          term_q, term_d;
  logic [7:0]          ipg_q, ipg_d;

  blk_t                slot_type [SLOTS];
  logic [2:0]          slot_term [SLOTS];

  logic [BODY_W-1:0]   body, low_mask, keep_mask;
  logic [3:0]          flags;
  logic [1:0]          first_ctrl;
  logic                all_data;
  logic [2:0]          n_term;
  logic [TC_WIDTH-1:0] word_d, tx_q;
  logic                valid_q;
  logic [31:0]         block_cnt_q, data_cnt_q, pkt_cnt_q;

  function automatic logic [7:0] type_byte(blk_t t, logic [2:0] k);
    logic [7:0] b;
    b = 8'h1E;
    if (t == BLK_S) begin
      b = 8'h78;
    end else if (t == BLK_T) begin
      case (k)
        3'd0:    b = 8'h87;
        3'd1:    b = 8'h99;
        3'd2:    b = 8'hAA;
        3'd3:    b = 8'hB4;
        3'd4:    b = 8'hCC;
        3'd5:    b = 8'hD2;
        3'd6:    b = 8'hE1;
        default: b = 8'hFF;
      endcase
    end
    return b;
  endfunction

  // T(k) payload: k data bytes, (7-k) zero pad bits, then (7-k) 7-bit control characters
  function automatic logic [PAY_W-1:0] payload(blk_t t, logic [2:0] k);
    logic [PAY_W-1:0] p;
    p = {8{IDLE_CHAR_PATTERN}};
    if (t == BLK_S) begin
      p = {7{DATA_CHAR_PATTERN}};
    end else if (t == BLK_T) begin
      p = '0;
      for (int b = 0; b < 7; b++) begin
        if (b < int'(k))
          p[8*b +: 8] = DATA_CHAR_PATTERN;
        if (b < 7 - int'(k))
          p[7*int'(k) + 7 + 7*b +: 7] = CTRL_CHAR_PATTERN;
      end
    end
    return p;
  endfunction

  // Per-slot sequencer: each slot advances a copy of the state, so several S in one
  // cycle all sample the same inputs.
  always_comb begin
    phase_d = phase_q;
    rem_d   = rem_q;
    term_d  = term_q;
    ipg_d   = ipg_q;
    for (int j = 0; j < SLOTS; j++) begin
      slot_type[j] = BLK_I;
      slot_term[j] = term_d;
      if (phase_d == PH_IDLE) begin
        if (rem_d != 8'd0) begin
          rem_d = rem_d - 8'd1;
        end else if (bus.i_enable) begin
          slot_type[j] = BLK_S;
          term_d  = bus.i_term_bytes;
          ipg_d   = (bus.i_ipg_blocks == 8'd0) ? 8'd1 : bus.i_ipg_blocks;
          rem_d   = bus.i_data_blocks;
          phase_d = PH_DATA;
        end
      end else if (rem_d != 8'd0) begin
        slot_type[j] = BLK_D;
        rem_d = rem_d - 8'd1;
      end else begin
        slot_type[j] = BLK_T;
        rem_d   = ipg_d;
        phase_d = PH_IDLE;
      end
    end
  end

  // Lay the slots out as plain 64b blocks, then drop the first control slot's low type
  // nibble and lift the slots below it by four bits to make room for the flags.
  always_comb begin
    all_data   = 1'b1;
    flags      = '0;
    first_ctrl = '0;
    n_term     = '0;
    body       = '0;
    for (int j = SLOTS - 1; j >= 0; j--) begin
      if (slot_type[j] == BLK_D) begin
        flags[j] = 1'b1;
        body[DATA_WIDTH*j +: DATA_WIDTH] = {8{DATA_CHAR_PATTERN}};
      end else begin
        all_data   = 1'b0;
        first_ctrl = 2'(j);
        body[DATA_WIDTH*j +: DATA_WIDTH] = {payload(slot_type[j], slot_term[j]),
                                            type_byte(slot_type[j], slot_term[j])};
      end
      if (slot_type[j] == BLK_T)
        n_term = n_term + 3'd1;
    end
    low_mask  = (BODY_W'(1) << (DATA_WIDTH * int'(first_ctrl))) - BODY_W'(1);
    keep_mask = ~((BODY_W'(1) << (DATA_WIDTH * int'(first_ctrl) + 4)) - BODY_W'(1));
    if (all_data)
      word_d = {body, 1'b1};
    else
      word_d = {(body & keep_mask) | ((body & low_mask) << 4) | BODY_W'(flags), 1'b0};
    if (bus.i_err_inject)
      word_d[12:5] = word_d[12:5] ^ 8'hFF;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q     <= PH_IDLE;
      rem_q       <= '0;
      term_q      <= '0;
      ipg_q       <= '0;
      tx_q        <= '0;
      valid_q     <= 1'b0;
      block_cnt_q <= '0;
      data_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      phase_q     <= phase_d;
      rem_q       <= rem_d;
      term_q      <= term_d;
      ipg_q       <= ipg_d;
      tx_q        <= word_d;
      valid_q     <= 1'b1;
      block_cnt_q <= block_cnt_q + 32'd1;
      data_cnt_q  <= data_cnt_q + 32'(all_data);
      pkt_cnt_q   <= pkt_cnt_q + 32'(n_term);
    end
  end

  assign bus.o_tx_coded    = tx_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_block_count = block_cnt_q;
  assign bus.o_data_count  = data_cnt_q;
  assign bus.o_pkt_count   = pkt_cnt_q;
endmodule

// File: tb/tb_baser_257b_generator.sv
// Self-checking bench for baser_257b_generator: a block-stream reference model feeds a
// scoreboard, driven by a vector table plus hand-built corner-case sequences.
module tb_baser_257b_generator;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  baser_257b_generator_if bus ();
  baser_257b_generator dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));

  // kind: 0=I 1=S 2=D 3=T
  typedef struct { int kind; int k; } blk_s;
  typedef struct { logic [256:0] word; logic [31:0] blocks; logic [31:0] datas; logic [31:0] pkts; } exp_s;
  typedef struct { bit en; int db; int tb; int ipg; bit err; int cycles; } vec_t;

  blk_s         pend[$];
  exp_s         sb[$];
  logic [31:0]  m_blocks, m_datas, m_pkts;
  logic [256:0] last_clean;
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [256:0] act, input logic [256:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] m_type(int kind, int k);
    if (kind == 1) return 8'h78;
    if (kind == 3) begin
      case (k)
        0: return 8'h87;  1: return 8'h99;  2: return 8'hAA;  3: return 8'hB4;
        4: return 8'hCC;  5: return 8'hD2;  6: return 8'hE1;  default: return 8'hFF;
      endcase
    end
    return 8'h1E;
  endfunction

  function automatic logic [55:0] m_payload(int kind, int k);
    logic [7:0]  d;
    logic [6:0]  c;
    logic [6:0]  idl;
    logic [55:0] p;
    d = 8'hAA; c = 7'h1E; idl = 7'h00; p = '0;
    if (kind == 1) begin
      for (int i = 0; i < 56; i++) p[i] = d[i % 8];
    end else if (kind == 3) begin
      for (int i = 0; i < 8 * k; i++) p[i] = d[i % 8];
      for (int i = 0; i < 7 * (7 - k); i++) p[8 * k + (7 - k) + i] = c[i % 7];
    end else begin
      for (int i = 0; i < 56; i++) p[i] = idl[i % 7];
    end
    return p;
  endfunction

  // Expands whole packets into a pending block queue, then packs bit by bit.
  task automatic model_cycle(input bit en, input int db, input int tb, input int ipg, input bit err);
    int           kind[4];
    int           kk[4];
    int           first, npk;
    bit           alld;
    logic [256:0] w;
    logic [63:0]  v;
    logic [63:0]  dpat;
    logic [7:0]   ty;
    logic [55:0]  pl;
    blk_s         nb;
    exp_s         e;
    dpat = {8{8'hAA}};
    for (int j = 0; j < 4; j++) begin
      if (pend.size() == 0) begin
        kind[j] = en ? 1 : 0;
        kk[j]   = 0;
        if (en) begin
          nb.kind = 2; nb.k = 0;
          for (int n = 0; n < db; n++) pend.push_back(nb);
          nb.kind = 3; nb.k = tb;
          pend.push_back(nb);
          nb.kind = 0; nb.k = 0;
          for (int n = 0; n < ((ipg == 0) ? 1 : ipg); n++) pend.push_back(nb);
        end
      end else begin
        nb = pend.pop_front();
        kind[j] = nb.kind;
        kk[j]   = nb.k;
      end
    end
    w = '0; alld = 1'b1; first = -1; npk = 0;
    for (int j = 0; j < 4; j++) begin
      if (kind[j] != 2) begin
        alld = 1'b0;
        if (first < 0) first = j;
      end
      if (kind[j] == 3) npk++;
    end
    if (alld) begin
      w[0] = 1'b1;
      for (int j = 0; j < 4; j++)
        for (int b = 0; b < 64; b++) w[1 + 64 * j + b] = dpat[b];
    end else begin
      for (int j = 0; j < 4; j++) begin
        w[1 + j] = (kind[j] == 2);
        ty = m_type(kind[j], kk[j]);
        pl = m_payload(kind[j], kk[j]);
        v  = (kind[j] == 2) ? dpat : {pl, ty};
        if (j < first) begin
          for (int b = 0; b < 64; b++) w[5 + 64 * j + b] = v[b];
        end else if (j == first) begin
          for (int b = 0; b < 4; b++)  w[5 + 64 * j + b] = ty[4 + b];
          for (int b = 0; b < 56; b++) w[9 + 64 * j + b] = pl[b];
        end else begin
          for (int b = 0; b < 64; b++) w[1 + 64 * j + b] = v[b];
        end
      end
    end
    last_clean = w;
    if (err)
      for (int b = 5; b <= 12; b++) w[b] = ~w[b];
    m_blocks = m_blocks + 32'd1;
    if (alld) m_datas = m_datas + 32'd1;
    m_pkts = m_pkts + 32'(npk);
    e.word = w; e.blocks = m_blocks; e.datas = m_datas; e.pkts = m_pkts;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_s e;
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL scoreboard: got empty queue, required one pending word");
      return;
    end
    e = sb.pop_front();
    check("valid", 257'(bus.o_valid), 257'(1));
    check("word", bus.o_tx_coded, e.word);
    check("block_count", 257'(bus.o_block_count), 257'(e.blocks));
    check("data_count", 257'(bus.o_data_count), 257'(e.datas));
    check("pkt_count", 257'(bus.o_pkt_count), 257'(e.pkts));
  endtask

  task automatic setInputs(input bit en, input int db, input int tb, input int ipg, input bit err);
    bus.i_enable      = en;
    bus.i_data_blocks = 8'(db);
    bus.i_term_bytes  = 3'(tb);
    bus.i_ipg_blocks  = 8'(ipg);
    bus.i_err_inject  = err;
  endtask

  task automatic applyStimulus(input bit en, input int db, input int tb, input int ipg, input bit err);
    setInputs(en, db, tb, ipg, err);
    model_cycle(en, db, tb, ipg, err);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases just after an edge.
  task automatic doReset(input bit en, input int db, input int tb, input int ipg);
    rst_n = 1'b0;
    pend.delete();
    sb.delete();
    m_blocks = '0; m_datas = '0; m_pkts = '0;
    #1;
    check("reset word", bus.o_tx_coded, '0);
    check("reset valid", 257'(bus.o_valid), 257'(0));
    check("reset block_count", 257'(bus.o_block_count), 257'(0));
    check("reset data_count", 257'(bus.o_data_count), 257'(0));
    check("reset pkt_count", 257'(bus.o_pkt_count), 257'(0));
    setInputs(en, db, tb, ipg, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t         vecs[8];
    logic [256:0] idle_w, sddt_w, alld_w, errmask;

    vecs[0] = '{en: 1, db: 2,   tb: 3, ipg: 1,   err: 0, cycles: 6};
    vecs[1] = '{en: 1, db: 8,   tb: 5, ipg: 0,   err: 0, cycles: 6};
    vecs[2] = '{en: 1, db: 0,   tb: 0, ipg: 1,   err: 0, cycles: 4};
    vecs[3] = '{en: 0, db: 5,   tb: 7, ipg: 3,   err: 0, cycles: 4};
    vecs[4] = '{en: 1, db: 1,   tb: 7, ipg: 4,   err: 1, cycles: 1};
    vecs[5] = '{en: 1, db: 1,   tb: 6, ipg: 4,   err: 0, cycles: 5};
    vecs[6] = '{en: 1, db: 255, tb: 2, ipg: 2,   err: 0, cycles: 70};
    vecs[7] = '{en: 1, db: 3,   tb: 1, ipg: 255, err: 0, cycles: 70};

    idle_w = '0;
    idle_w[8:5]     = 4'h1;
    idle_w[72:65]   = 8'h1E;
    idle_w[136:129] = 8'h1E;
    idle_w[200:193] = 8'h1E;

    sddt_w = '0;
    sddt_w[4:1]     = 4'b0110;
    sddt_w[8:5]     = 4'h7;
    sddt_w[64:9]    = {7{8'hAA}};
    sddt_w[128:65]  = {8{8'hAA}};
    sddt_w[192:129] = {8{8'hAA}};
    sddt_w[256:193] = {{4{7'h1E}}, 4'b0000, {3{8'hAA}}, 8'hB4};

    alld_w  = {{32{8'hAA}}, 1'b1};
    errmask = '0;
    errmask[12:5] = 8'hFF;

    #1;
    $display("[TB] idle traffic after reset");
    doReset(0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 0, 0);
      check("idle word", bus.o_tx_coded, idle_w);
    end

    $display("[TB] S D D T packet");
    doReset(1, 2, 3, 1);
    applyStimulus(1, 2, 3, 1, 0);
    check("SDDT word", bus.o_tx_coded, sddt_w);
    check("SDDT pkt_count", 257'(bus.o_pkt_count), 257'(1));
    for (int c = 0; c < 3; c++) applyStimulus(1, 2, 3, 1, 0);

    $display("[TB] all-data word");
    doReset(1, 8, 5, 0);
    applyStimulus(1, 8, 5, 0, 0);
    applyStimulus(1, 8, 5, 0, 0);
    check("all-data word", bus.o_tx_coded, alld_w);
    check("all-data data_count", 257'(bus.o_data_count), 257'(1));
    for (int c = 0; c < 3; c++) applyStimulus(1, 8, 5, 0, 0);

    $display("[TB] back-to-back short packets and error injection");
    doReset(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 0);
    check("STIS pkt_count", 257'(bus.o_pkt_count), 257'(1));
    applyStimulus(1, 0, 0, 1, 0);
    check("TIST pkt_count", 257'(bus.o_pkt_count), 257'(3));
    applyStimulus(1, 0, 0, 1, 0);
    check("ISTI pkt_count", 257'(bus.o_pkt_count), 257'(4));
    applyStimulus(1, 0, 0, 1, 1);
    check("err bits", bus.o_tx_coded ^ last_clean, errmask);
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 0, 1, 0);

    $display("[TB] vector table");
    foreach (vecs[i])
      for (int c = 0; c < vecs[i].cycles; c++)
        applyStimulus(vecs[i].en, vecs[i].db, vecs[i].tb, vecs[i].ipg, vecs[i].err);

    $display("[TB] random traffic");
    for (int c = 0; c < 60; c++)
      applyStimulus(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 7) == 0));

    $display("[TB] reset in the middle of a packet");
    applyStimulus(1, 20, 2, 3, 0);
    applyStimulus(1, 20, 2, 3, 0);
    #3;
    doReset(1, 4, 1, 2);
    applyStimulus(1, 4, 1, 2, 0);
    check("restart S type", 257'(bus.o_tx_coded[8:5]), 257'(4'h7));
    check("restart slot0 flag", 257'(bus.o_tx_coded[1]), 257'(0));
    for (int c = 0; c < 4; c++) applyStimulus(1, 4, 1, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
